pingpong_framebuf: RTL and testbench

PINGPONG_FRAMEBUF -- requirements
Module: pingpong_framebuf

---
 rtl/pingpong_framebuf.sv | 124 ++++++++++++
 tb/tb_pingpong_framebuf.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pingpong_framebuf.sv
// Double-buffered downsampled frame store: a writer fills the back buffer while the VGA
// scan reads the front buffer; buffers swap at the first start-of-frame after frame_done.
module pingpong_framebuf #(
  parameter  int H_PIXELS  = 640,
  parameter  int V_PIXELS  = 480,
  parameter  int SCALE     = 20,
  parameter  int PIX_W     = 8,
  localparam int DS_WIDTH  = H_PIXELS / SCALE,
  localparam int DS_HEIGHT = V_PIXELS / SCALE,
  localparam int RAM_SIZE  = DS_WIDTH * DS_HEIGHT,
  localparam int ADDR_W    = $clog2(RAM_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        hc,
  input  logic [9:0]        vc,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              wr_en,
  input  logic              frame_done,
  output logic              wr_ready,
  output logic              swap_pending,
  output logic              wr_err,
  output logic [15:0]       swap_count,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              pixel_valid
);

  localparam logic [ADDR_W:0]   RAM_LIM  = (ADDR_W+1)'(RAM_SIZE);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(RAM_SIZE - 1);

  typedef enum logic [1:0] {CLEAR, WRITE, PENDING} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic              rd_sel;
  logic [PIX_W-1:0]  mem0 [RAM_SIZE];
  logic [PIX_W-1:0]  mem1 [RAM_SIZE];

  logic sof, wr_in_range, wr_ok, swap;
  assign sof         = (hc == 10'd0) && (vc == 10'd0);
  assign wr_in_range = {1'b0, wr_addr} < RAM_LIM;
  assign wr_ok       = (state == WRITE) && wr_en && wr_in_range;
  assign swap        = (state == PENDING) && sof;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= CLEAR;
      clr_addr     <= '0;
      rd_sel       <= 1'b0;
      wr_ready     <= 1'b0;
      swap_pending <= 1'b0;
      wr_err       <= 1'b0;
      swap_count   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == CLR_LAST) begin
            clr_addr <= '0;
            state    <= WRITE;
            wr_ready <= 1'b1;
          end
        end
        WRITE: begin
          if (wr_en && !wr_in_range) wr_err <= 1'b1;
          // a coincident sof is deliberately ignored; the swap waits for the next one
          if (frame_done) begin
            state        <= PENDING;
            wr_ready     <= 1'b0;
            swap_pending <= 1'b1;
          end
        end
        PENDING: begin
          if (wr_en) wr_err <= 1'b1;
          if (sof) begin
            rd_sel       <= ~rd_sel;
            swap_count   <= swap_count + 16'd1;
            state        <= WRITE;
            wr_ready     <= 1'b1;
            swap_pending <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Clear zeroes both buffers; normal writes only ever reach the back buffer.
  always_ff @(posedge clk) begin
    if (!rst && state == CLEAR) begin
      mem0[clr_addr] <= '0;
      mem1[clr_addr] <= '0;
    end else if (!rst && wr_ok) begin
      if (rd_sel) mem0[wr_addr] <= wr_data;
      else        mem1[wr_addr] <= wr_data;
    end
  end

  logic [20:0]       hc_w, vc_w, ra_full;
  logic [ADDR_W-1:0] rd_addr;
  logic              active, rd_hit, sel;
  assign hc_w    = 21'(hc);
  assign vc_w    = 21'(vc);
  assign ra_full = (vc_w / 21'(SCALE)) * 21'(DS_WIDTH) + hc_w / 21'(SCALE);
  assign rd_addr = ra_full[ADDR_W-1:0];
  assign active  = (hc_w < 21'(H_PIXELS)) && (vc_w < 21'(V_PIXELS));
  assign rd_hit  = active && (ra_full < 21'(RAM_SIZE)) && (state != CLEAR);
  // in the swap cycle read from the buffer about to be displayed
  assign sel     = rd_sel ^ swap;

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_valid <= active;
      if (!rd_hit)  pixel_out <= '0;
      else if (sel) pixel_out <= mem1[rd_addr];
      else          pixel_out <= mem0[rd_addr];
    end
  end

endmodule

// File: tb/tb_pingpong_framebuf.sv
// Directed bench for pingpong_framebuf at default geometry (32x24 blocks, 768 words).
module tb_pingpong_framebuf;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [9:0]        hc, vc;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_en, frame_done;
  logic              wr_ready, swap_pending, wr_err, pixel_valid;
  logic [15:0]       swap_count;
  logic [7:0]        pixel_out;

  int total = 0;
  int bad   = 0;
  int n;

  pingpong_framebuf dut (
    .clk(clk), .rst(rst), .hc(hc), .vc(vc),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .frame_done(frame_done),
    .wr_ready(wr_ready), .swap_pending(swap_pending), .wr_err(wr_err),
    .swap_count(swap_count), .pixel_out(pixel_out), .pixel_valid(pixel_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int h, input int v);
    hc = 10'(h); vc = 10'(v);
    tick();
  endtask

  task automatic wait_ready(input string tag);
    n = 0;
    while (!wr_ready && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, n, 768);
  endtask

  initial begin
    rst = 1'b1; hc = 10'd700; vc = 10'd10;
    wr_addr = '0; wr_data = '0; wr_en = 1'b0; frame_done = 1'b0;
    tick(); tick();
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_pending", swap_pending, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_swap_count", swap_count, 0);
    chk("rst_pixel_out", pixel_out, 0);
    chk("rst_pixel_valid", pixel_valid, 0);

    rst = 1'b0;
    wait_ready("clear_cycles");
    rd(20, 20);
    chk("first_frame_pix", pixel_out, 0);
    chk("first_frame_valid", pixel_valid, 1);

    // out-of-range write in WRITE
    wr_en = 1'b1; wr_addr = 10'd800; wr_data = 8'hEE; tick();
    chk("oor_wr_err", wr_err, 1);
    wr_addr = 10'd33; wr_data = 8'hA5; tick();
    wr_en = 1'b0;
    rd(20, 20);
    chk("back_not_shown", pixel_out, 0);

    frame_done = 1'b1; hc = 10'd700; tick(); frame_done = 1'b0;
    chk("pending_set", swap_pending, 1);
    chk("pending_ready", wr_ready, 0);
    tick();
    chk("pending_holds", swap_pending, 1);

    rd(0, 0);
    chk("swap1_count", swap_count, 1);
    chk("swap1_pending", swap_pending, 0);
    chk("swap1_ready", wr_ready, 1);
    chk("swap1_pix00", pixel_out, 0);
    rd(20, 20);
    chk("blk33_pix", pixel_out, 8'hA5);
    chk("blk33_valid", pixel_valid, 1);
    rd(39, 39);
    chk("blk33_edge", pixel_out, 8'hA5);
    rd(40, 20);
    chk("blk34_pix", pixel_out, 0);
    rd(700, 10);
    chk("inactive_h_pix", pixel_out, 0);
    chk("inactive_h_valid", pixel_valid, 0);
    rd(100, 480);
    chk("inactive_v_valid", pixel_valid, 0);
    rd(639, 479);
    chk("last_px_valid", pixel_valid, 1);
    chk("last_px_pix", pixel_out, 0);
    chk("wr_err_sticky", wr_err, 1);

    // write to the new back buffer, sof while in WRITE must not swap
    wr_en = 1'b1; wr_addr = 10'd0; wr_data = 8'h3C; hc = 10'd700; tick(); wr_en = 1'b0;
    rd(0, 0);
    chk("sof_write_no_swap", swap_count, 1);
    chk("display_untouched", pixel_out, 0);

    // frame_done on the sof cycle: swap deferred to the next sof
    hc = 10'd0; vc = 10'd0; frame_done = 1'b1; tick(); frame_done = 1'b0;
    chk("fd_sof_pending", swap_pending, 1);
    chk("fd_sof_no_swap", swap_count, 1);
    rd(700, 10);
    chk("fd_sof_wait", swap_count, 1);
    rd(0, 0);
    chk("swap2_count", swap_count, 2);
    chk("swap2_pix00", pixel_out, 8'h3C);
    rd(20, 20);
    chk("swap2_blk33", pixel_out, 0);

    // reset while pending, with competing inputs
    frame_done = 1'b1; hc = 10'd700; tick(); frame_done = 1'b0;
    chk("pending_again", swap_pending, 1);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 10'd0; wr_data = 8'hFF; frame_done = 1'b1;
    hc = 10'd0; vc = 10'd0; tick();
    wr_en = 1'b0; frame_done = 1'b0; hc = 10'd700; vc = 10'd10;
    chk("rst2_pending", swap_pending, 0);
    chk("rst2_count", swap_count, 0);
    chk("rst2_wr_err", wr_err, 0);
    chk("rst2_ready", wr_ready, 0);
    chk("rst2_pixel", pixel_out, 0);
    rst = 1'b0;
    wait_ready("clear2_cycles");
    hc = 10'd0; vc = 10'd0; tick();
    chk("rezeroed_pix00", pixel_out, 0);
    chk("rst2_no_swap", swap_count, 0);

    // write while pending is refused and flagged
    frame_done = 1'b1; hc = 10'd700; tick(); frame_done = 1'b0;
    wr_en = 1'b1; wr_addr = 10'd1; wr_data = 8'h77; tick(); wr_en = 1'b0;
    chk("pend_wr_err", wr_err, 1);
    rd(0, 0);
    chk("swap3_count", swap_count, 1);
    rd(20, 0);
    chk("pend_wr_dropped", pixel_out, 0);
    chk("wr_err_sticky2", wr_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
